psi_stream_thresh: RTL

- Sequential, parametrised successor to the one-shot combinational PSI.
- N parties' W-bit membership bitmaps stream in as C-bit chunks per beat, not as one N*W-bit flat word.
- Per bit position, the block counts how many parties hold the element and emits 1 when count >= threshold:
  - threshold = N gives strict intersection;
  - lower thresholds give threshold-PSI.
- Sits between the party-share input packer and the MPC output collector; valid/ready on both sides.

---
 rtl/psi_pkg.sv | 20 ++
 rtl/psi_bit_vote.sv | 21 ++
 rtl/psi_stream_thresh.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/psi_pkg.sv
// Shared types and width helpers for the streaming threshold-PSI block.
package psi_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} psi_state_e;

   localparam int unsigned DefN = 4;
   localparam int unsigned DefW = 64;
   localparam int unsigned DefC = 8;

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned count_width(int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   // Bits for a beat index; a single-beat job still needs a 1-bit counter.
   function automatic int unsigned beat_width(int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/psi_bit_vote.sv
// One bit lane: counts how many parties hold the element and compares to the threshold.
module psi_bit_vote #(
   parameter int unsigned N  = 4,
   parameter int unsigned TW = 3
) (
   input  logic [N-1:0]  party_bits,
   input  logic [TW-1:0] thresh,
   output logic          vote
);

   logic [TW-1:0] cnt;

   always_comb begin
      cnt = '0;
      for (int p = 0; p < N; p++) begin
         cnt = cnt + TW'(party_bits[p]);
      end
      vote = (cnt >= thresh);
   end

endmodule

// File: rtl/psi_stream_thresh.sv
// Streaming threshold PSI: C-bit chunks of N party bitmaps in, one voted chunk out per beat.
// Optional result popcount on `card` when PSI_CARDINALITY_EN is defined.
module psi_stream_thresh
   import psi_pkg::*;
#(
   parameter int unsigned N = DefN,
   parameter int unsigned W = DefW,
   parameter int unsigned C = DefC,
   localparam int unsigned TW = count_width(N),
   localparam int unsigned CW = count_width(W)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [TW-1:0]   thresh,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*C-1:0]  in_chunk,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [C-1:0]    out_chunk,
   output logic            out_last,
   output logic            busy,
   output logic            done
`ifdef PSI_CARDINALITY_EN
   ,
   output logic [CW-1:0]   card
`endif
);

   localparam int unsigned Beats = W / C;
   localparam int unsigned BW    = beat_width(Beats);
   localparam logic [BW-1:0] LastBeat = BW'(Beats - 1);

   if (W % C != 0) begin : gen_width_check
      $error("psi_stream_thresh: W must be a multiple of C");
   end
   if (N < 2) begin : gen_party_check
      $error("psi_stream_thresh: N must be at least 2");
   end

   psi_state_e      state_q, state_d;
   logic [TW-1:0]   thresh_q;
   logic [BW-1:0]   beat_q;
   logic            out_valid_q;
   logic            out_last_q;
   logic [C-1:0]    out_chunk_q;
   logic            in_hs;
   logic            out_hs;
   logic            last_beat;
   logic [C-1:0]    vote;
   logic [C-1:0][N-1:0] lane_bits;

   // Transpose party-major input into one N-bit vector per bit lane.
   for (genvar i = 0; i < C; i++) begin : gen_lane
      for (genvar p = 0; p < N; p++) begin : gen_party
         assign lane_bits[i][p] = in_chunk[p*C + i];
      end
      psi_bit_vote #(
         .N  (N),
         .TW (TW)
      ) u_vote (
         .party_bits (lane_bits[i]),
         .thresh     (thresh_q),
         .vote       (vote[i])
      );
   end

   assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid_q && out_ready;
   assign last_beat = (beat_q == LastBeat);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (in_hs && last_beat) state_d = StFlush;
         StFlush: if (out_hs && out_last_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         thresh_q    <= TW'(N);
         beat_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_chunk_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            thresh_q <= (thresh == '0) ? TW'(N) : thresh;
            beat_q   <= '0;
         end else if (in_hs) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
         end
         if (in_hs) begin
            out_valid_q <= 1'b1;
            out_chunk_q <= vote;
            out_last_q  <= last_beat;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_chunk = out_chunk_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == StRun) || (state_q == StFlush);
   assign done      = (state_q == StDone);

`ifdef PSI_CARDINALITY_EN
   logic [CW-1:0] card_q;
   logic [CW-1:0] chunk_pop;

   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < C; i++) begin
         chunk_pop = chunk_pop + CW'(vote[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         card_q <= '0;
      end else if (state_q == StIdle && start) begin
         card_q <= '0;
      end else if (in_hs) begin
         card_q <= card_q + chunk_pop;
      end
   end

   assign card = card_q;
`endif

endmodule
